// File: rtl/clk_div_sequencer_if.sv
// Command port of clk_div_sequencer: valid/ready command with opcode/argument,
// abort request and done/error completion status.
interface clk_div_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_arg;
   logic        abort;
   logic        done;
   logic        cmd_err;

   modport master (
      output cmd_valid, cmd_op, cmd_arg, abort,
      input  cmd_ready, done, cmd_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, abort,
      output cmd_ready, done, cmd_err
   );
endinterface

// File: rtl/clk_div_sequencer.sv
// Command-driven controller owning every ClkDivider control input: free-run, stop
// and exact N-edge stepping of clk_o. Optional WAIT watchdog via CLK_SEQ_TIMEOUT_EN.
module clk_div_sequencer #(
   parameter int unsigned COUNTER_BITS       = 32,
   parameter int unsigned PULSE_CONTROL_BITS = 32,
   parameter int unsigned DEFAULT_DIV        = 2,
   parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   clk_div_sequencer_if.slave            cmd,
   output logic                          busy,
   output logic [31:0]                   edge_count,
   input  logic                          clk_o,
   output logic                          option,
   output logic                          out_enable,
   output logic [COUNTER_BITS-1:0]       divider,
   output logic [PULSE_CONTROL_BITS-1:0] pulse,
   output logic                          write_pulse
);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_e;
   typedef enum logic [2:0] {
      OP_NOP = 3'd0, OP_SET_DIV = 3'd1, OP_RUN = 3'd2,
      OP_STOP = 3'd3, OP_STEP = 3'd4, OP_CLR_CNT = 3'd5
   } op_e;

   state_e                        state_q, state_d;
   logic                          clk_o_q;
   logic                          rise, accept;
   logic                          done_q, done_d, err_q, err_d;
   logic                          abort_pend, abort_pend_d;
   logic                          option_d, out_enable_d, write_pulse_d;
   logic [COUNTER_BITS-1:0]       divider_d, arg_div;
   logic [PULSE_CONTROL_BITS-1:0] pulse_d, arg_pulse, step_cnt, step_cnt_d;
   logic [31:0]                   edge_count_d;
`ifdef CLK_SEQ_TIMEOUT_EN
   logic [31:0]                   wd_q, wd_d;
`endif

   assign rise          = clk_o & ~clk_o_q;
   assign cmd.cmd_ready = (state_q == IDLE) & ~cmd.abort & reset;
   assign accept        = cmd.cmd_valid & cmd.cmd_ready;
   assign cmd.done      = done_q;
   assign cmd.cmd_err   = err_q;
   assign busy          = (state_q != IDLE);
   assign arg_div       = COUNTER_BITS'(cmd.cmd_arg);
   assign arg_pulse     = PULSE_CONTROL_BITS'(cmd.cmd_arg);

   always_comb begin
      state_d       = state_q;
      option_d      = option;
      out_enable_d  = out_enable;
      divider_d     = divider;
      pulse_d       = pulse;
      write_pulse_d = 1'b0;
      done_d        = 1'b0;
      err_d         = 1'b0;
      step_cnt_d    = step_cnt;
      abort_pend_d  = abort_pend;
      edge_count_d  = rise ? edge_count + 32'd1 : edge_count;
`ifdef CLK_SEQ_TIMEOUT_EN
      wd_d          = wd_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               done_d = 1'b1;
               case (cmd.cmd_op)
                  OP_NOP: ;
                  OP_SET_DIV: begin
                     if (arg_div == '0) err_d = 1'b1;
                     else               divider_d = arg_div;
                  end
                  OP_RUN: begin
                     option_d     = 1'b1;
                     out_enable_d = 1'b1;
                  end
                  OP_STOP:    out_enable_d = 1'b0;
                  OP_CLR_CNT: edge_count_d = '0;
                  OP_STEP: begin
                     if (arg_pulse != '0) begin
                        done_d        = 1'b0;
                        option_d      = 1'b0;
                        out_enable_d  = 1'b1;
                        pulse_d       = arg_pulse;
                        write_pulse_d = 1'b1;
                        step_cnt_d    = '0;
                        abort_pend_d  = 1'b0;
                        state_d       = LOAD;
                     end
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         LOAD: begin
            // An abort seen here is held so it still fires in the first WAIT cycle.
            abort_pend_d = cmd.abort;
            state_d      = WAIT;
`ifdef CLK_SEQ_TIMEOUT_EN
            wd_d         = '0;
`endif
         end
         WAIT: begin
            if (cmd.abort | abort_pend) begin
               out_enable_d = 1'b0;
               abort_pend_d = 1'b0;
               done_d       = 1'b1;
               err_d        = 1'b1;
               state_d      = IDLE;
            end else if (rise && (step_cnt + 1'b1 == pulse)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (rise) begin
               step_cnt_d = step_cnt + 1'b1;
`ifdef CLK_SEQ_TIMEOUT_EN
               wd_d       = '0;
            end else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
               out_enable_d = 1'b0;
               done_d       = 1'b1;
               err_d        = 1'b1;
               state_d      = IDLE;
            end else begin
               wd_d = wd_q + 32'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         clk_o_q     <= 1'b0;
         option      <= 1'b1;
         out_enable  <= 1'b0;
         divider     <= COUNTER_BITS'(DEFAULT_DIV);
         pulse       <= '0;
         write_pulse <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         edge_count  <= '0;
         step_cnt    <= '0;
         abort_pend  <= 1'b0;
`ifdef CLK_SEQ_TIMEOUT_EN
         wd_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         clk_o_q     <= clk_o;
         option      <= option_d;
         out_enable  <= out_enable_d;
         divider     <= divider_d;
         pulse       <= pulse_d;
         write_pulse <= write_pulse_d;
         done_q      <= done_d;
         err_q       <= err_d;
         edge_count  <= edge_count_d;
         step_cnt    <= step_cnt_d;
         abort_pend  <= abort_pend_d;
`ifdef CLK_SEQ_TIMEOUT_EN
         wd_q        <= wd_d;
`endif
      end
   end

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed self-checking bench for clk_div_sequencer; clk_o is driven by the bench
// so every rise and its effect on edge_count/STEP completion is known exactly.
module tb_clk_div_sequencer;

   localparam int unsigned TIMEOUT = 1024;

   logic        clk, reset, busy, clk_o, option, out_enable, write_pulse;
   logic [31:0] edge_count, divider, pulse;
   int unsigned checks = 0;
   int unsigned errors = 0;

   clk_div_sequencer_if cmd_if ();

   clk_div_sequencer #(
      .COUNTER_BITS(32), .PULSE_CONTROL_BITS(32),
      .DEFAULT_DIV(2), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .cmd(cmd_if), .busy(busy),
      .edge_count(edge_count), .clk_o(clk_o), .option(option),
      .out_enable(out_enable), .divider(divider), .pulse(pulse),
      .write_pulse(write_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, want finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Called at a negedge; returns at the negedge of the cycle after acceptance.
   task automatic issue(input logic [2:0] op, input logic [31:0] arg);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_arg   = arg;
      #1;
      check("issue_ready", cmd_if.cmd_ready, 1);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic rises(input int unsigned n, input int unsigned half);
      for (int unsigned i = 0; i < n; i++) begin
         clk_o = 1'b1;
         repeat (half) @(negedge clk);
         clk_o = 1'b0;
         repeat (half) @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b0;
      clk_o = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = '0;
      cmd_if.cmd_arg   = '0;
      cmd_if.abort     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready_low", cmd_if.cmd_ready, 0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_ready", cmd_if.cmd_ready, 1);
      check("rst_divider", divider, 2);
      check("rst_option", option, 1);
      check("rst_out_en", out_enable, 0);
      check("rst_edges", edge_count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", cmd_if.done, 0);

      issue(3'd1, 32'd4);
      check("setdiv_done", cmd_if.done, 1);
      check("setdiv_err", cmd_if.cmd_err, 0);
      check("setdiv_val", divider, 4);
      issue(3'd2, 32'd0);
      check("run_done", cmd_if.done, 1);
      check("run_out_en", out_enable, 1);
      check("run_option", option, 1);
      rises(3, 4);
      check("run_done_clear", cmd_if.done, 0);
      check("run_edges", edge_count, 3);

      issue(3'd3, 32'd0);
      check("stop_done", cmd_if.done, 1);
      check("stop_out_en", out_enable, 0);
      check("stop_option", option, 1);

      // Clear collides with a rise in the same cycle: the clear wins.
      clk_o = 1'b1;
      issue(3'd5, 32'd0);
      check("clr_done", cmd_if.done, 1);
      check("clr_edges", edge_count, 0);
      clk_o = 1'b0;
      @(negedge clk);

      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 3'd4; cmd_if.cmd_arg = 32'd8;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      check("step8_wp", write_pulse, 1);
      check("step8_pulse", pulse, 8);
      check("step8_option", option, 0);
      check("step8_out_en", out_enable, 1);
      check("step8_busy_load", busy, 1);
      check("step8_ready_load", cmd_if.cmd_ready, 0);
      check("step8_nodone_load", cmd_if.done, 0);
      @(negedge clk);
      check("step8_wp_once", write_pulse, 0);
      for (int unsigned i = 0; i < 8; i++) begin
         clk_o = 1'b1;
         @(negedge clk);
         if (i < 7) begin
            check("step8_busy", busy, 1);
            check("step8_nodone", cmd_if.done, 0);
            check("step8_ready", cmd_if.cmd_ready, 0);
         end else begin
            check("step8_done", cmd_if.done, 1);
            check("step8_err", cmd_if.cmd_err, 0);
            check("step8_idle", busy, 0);
            check("step8_out_en_kept", out_enable, 1);
            check("step8_option_kept", option, 0);
         end
         clk_o = 1'b0;
         @(negedge clk);
      end
      check("step8_edges", edge_count, 8);

      // A rise while in LOAD is counted in edge_count but not toward the step.
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 3'd4; cmd_if.cmd_arg = 32'd2;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      clk_o = 1'b1;
      @(negedge clk);
      clk_o = 1'b0;
      check("load_rise_edges", edge_count, 9);
      @(negedge clk);
      clk_o = 1'b1;
      @(negedge clk);
      check("step2_not_done", cmd_if.done, 0);
      check("step2_busy", busy, 1);
      clk_o = 1'b0;
      @(negedge clk);
      clk_o = 1'b1;
      @(negedge clk);
      check("step2_done", cmd_if.done, 1);
      check("step2_err", cmd_if.cmd_err, 0);
      clk_o = 1'b0;
      @(negedge clk);

      issue(3'd1, 32'd0);
      check("div0_done", cmd_if.done, 1);
      check("div0_err", cmd_if.cmd_err, 1);
      check("div0_kept", divider, 4);
      issue(3'd7, 32'd9);
      check("op7_done", cmd_if.done, 1);
      check("op7_err", cmd_if.cmd_err, 1);
      check("op7_div_kept", divider, 4);
      issue(3'd4, 32'd0);
      check("step0_done", cmd_if.done, 1);
      check("step0_err", cmd_if.cmd_err, 0);
      check("step0_busy", busy, 0);
      check("step0_no_wp", write_pulse, 0);

      issue(3'd4, 32'd100);
      @(negedge clk);
      rises(3, 1);
      check("abort_still_busy", busy, 1);
      cmd_if.abort = 1'b1;
      @(negedge clk);
      check("abort_done", cmd_if.done, 1);
      check("abort_err", cmd_if.cmd_err, 1);
      check("abort_out_en", out_enable, 0);
      check("abort_idle", busy, 0);
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 3'd2;
      #1;
      check("abort_idle_ready", cmd_if.cmd_ready, 0);
      @(negedge clk);
      check("abort_idle_nodone", cmd_if.done, 0);
      check("abort_idle_no_run", out_enable, 0);
      cmd_if.cmd_valid = 1'b0;
      cmd_if.abort = 1'b0;
      @(negedge clk);

      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 3'd4; cmd_if.cmd_arg = 32'd5;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      cmd_if.abort = 1'b1;
      @(negedge clk);
      cmd_if.abort = 1'b0;
      check("abort_load_busy", busy, 1);
      check("abort_load_nodone", cmd_if.done, 0);
      @(negedge clk);
      check("abort_load_done", cmd_if.done, 1);
      check("abort_load_err", cmd_if.cmd_err, 1);
      check("abort_load_idle", busy, 0);

      issue(3'd4, 32'd10);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_wait_busy", busy, 0);
      check("rst_wait_done", cmd_if.done, 0);
      check("rst_wait_div", divider, 2);
      check("rst_wait_out_en", out_enable, 0);
      check("rst_wait_option", option, 1);
      check("rst_wait_edges", edge_count, 0);
      reset = 1'b1;
      @(negedge clk);

      issue(3'd4, 32'd5);
      @(negedge clk);
`ifdef CLK_SEQ_TIMEOUT_EN
      begin
         int unsigned cyc = 0;
         while (!cmd_if.done && cyc < 2 * TIMEOUT) begin
            @(negedge clk);
            cyc++;
         end
         check("wd_cycles", cyc, TIMEOUT);
         check("wd_err", cmd_if.cmd_err, 1);
         check("wd_out_en", out_enable, 0);
         check("wd_idle", busy, 0);
      end
`else
      repeat (TIMEOUT + 76) @(negedge clk);
      check("nowd_busy", busy, 1);
      check("nowd_nodone", cmd_if.done, 0);
      cmd_if.abort = 1'b1;
      @(negedge clk);
      cmd_if.abort = 1'b0;
      check("nowd_abort_done", cmd_if.done, 1);
      check("nowd_abort_err", cmd_if.cmd_err, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_div_sequencer.md
# clk_div_sequencer

Command-driven controller for the `ClkDivider` block. It owns every `ClkDivider` control input: `option`, `out_enable`, `divider`, `pulse` and `write_pulse`. It exposes a single valid/ready command port to the host-side controller logic, and supports free-run, stop and exact N-cycle stepping of the divided clock. It counts rising edges of `clk_o` to report step completion, and keeps a running edge count for status.

## Interface
- `COUNTER_BITS`, 32: width of `divider`.
- `PULSE_CONTROL_BITS`, 32: width of `pulse` and of the step count.
- `DEFAULT_DIV`, 2: `divider` value loaded at reset.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in `clk` cycles. Used only with `CLK_SEQ_TIMEOUT_EN`.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op` in 3: opcode. 0 NOP, 1 SET_DIV, 2 RUN, 3 STOP, 4 STEP, 5 CLR_CNT; 6 and 7 are illegal.
- `cmd_arg` in 32: argument. Low bits are used, truncated to the destination width.
- `abort` in 1: cancels an in-progress STEP.
- `done` out 1: one-cycle pulse when a command completes.
- `cmd_err` out 1: qualifies `done`; high means the command failed.
- `busy` out 1: high while in LOAD or WAIT.
- `edge_count` out 32: free-running count of `clk_o` rising edges.
- `clk_o` in 1: divided clock fed back from `ClkDivider`.
- `option` out 1: 1 = free-run, 0 = pulse mode.
- `out_enable` out 1: divider output enable.
- `divider` out COUNTER_BITS: divide value.
- `pulse` out PULSE_CONTROL_BITS: pulse count.
- `write_pulse` out 1: one-cycle strobe that loads `pulse`.

## Operation
- **States:** IDLE, LOAD, WAIT.
- **`cmd_ready`:** equals (state == IDLE) & ~abort & reset. It is forced to 0 while `reset` is low.
- **Edge detect:** `clk_o_q` registers `clk_o`; a rise is `clk_o & ~clk_o_q`. Every rise increments `edge_count`, which wraps at 2^32 in any state.
- **SET_DIV:** `divider` <= arg. An arg of 0 is rejected with `done` + `cmd_err` and `divider` is left unchanged. A divided clock period of at least 2 `clk` cycles is required for edge sampling.
- **RUN:** `option` = 1, `out_enable` = 1.
- **STOP:** `out_enable` = 0. `option` is unchanged.
- **CLR_CNT:** `edge_count` <= 0. If a rise occurs in the same cycle, the clear wins.
- **STEP n, n = 0:** `done` with no error; no outputs change.
- **STEP n, n > 0:** IDLE→LOAD. In LOAD: `option` = 0, `pulse` = n, `write_pulse` = 1, `out_enable` = 1. LOAD→WAIT unconditionally. WAIT counts rises. On the nth rise: →IDLE, then `done` = 1, `cmd_err` = 0. `out_enable` stays 1 and `option` stays 0.
- **Abort in WAIT:** `out_enable` <= 0, →IDLE, `done` + `cmd_err`. Abort in LOAD takes effect in the first WAIT cycle. Abort in IDLE blocks acceptance and has no other effect.
- **Illegal op (6, 7):** `done` + `cmd_err`; no state change.
- **NOP:** `done` with no error.

## Timing
- **Command accepted at cycle T:**
  - SET_DIV, RUN, STOP, CLR_CNT, NOP and illegal ops: register update and `done` both at T+1.
  - STEP: `write_pulse` high at T+1 only; WAIT from T+2.
  - STEP `done` is asserted the cycle after the cycle in which the nth rise is detected.
- **Reset values:** state IDLE; `option` = 1, `out_enable` = 0, `divider` = DEFAULT_DIV, `pulse` = 0, `write_pulse` = 0, `done` = 0, `cmd_err` = 0, `busy` = 0, `edge_count` = 0, `clk_o_q` = 0.
- **Reset during LOAD or WAIT:** aborts immediately to the reset values, with no `done`.
- **Rise counting:** rises before T+2 do not count toward a STEP. `edge_count` counts them regardless of state.

## Configuration
- **`CLK_SEQ_TIMEOUT_EN` defined:** a watchdog counter runs in WAIT. It clears on entry to WAIT and on every rise. On reaching TIMEOUT_CYCLES: `out_enable` <= 0, →IDLE, `done` + `cmd_err`.
- **`CLK_SEQ_TIMEOUT_EN` undefined:** there is no watchdog. WAIT exits only on the nth rise, on `abort`, or on reset. TIMEOUT_CYCLES is ignored.

## Test plan
- **Reset:** release reset → `cmd_ready` = 1 next cycle, `divider` = 2, `option` = 1, `out_enable` = 0, `edge_count` = 0.
- **SET_DIV then RUN:** SET_DIV 4 then RUN → `divider` = 4, `out_enable` = 1, `done` after each command, `edge_count` increments once per 8 `clk` cycles (nominal).
- **STEP 8:** `write_pulse` pulses once with `pulse` = 8, `busy` high, `done` (no error) the cycle after the 8th rise; `cmd_ready` stays low throughout.
- **Degenerate and illegal commands:** SET_DIV 0, op 7 and STEP 0 → `done` with `cmd_err` = 1, 1 and 0 respectively; `divider` is unchanged.
- **Abort:** STEP 100 with `abort` asserted after 3 rises → `out_enable` = 0, `done` + `cmd_err`, back to IDLE. Assert `abort` with `cmd_valid` in IDLE → command not accepted.
- **Watchdog (with `CLK_SEQ_TIMEOUT_EN`):** STEP 5 with `clk_o` held low → `done` + `cmd_err` exactly TIMEOUT_CYCLES cycles after WAIT entry. Without the macro, the block stays `busy`.
